gshare_update_ctrl: RTL and testbench
=====================================

Name: gshare_update_ctrl

Overview:
- Sequences all training traffic into the gshare predictor.
- Collects up to WIDTH resolved branches per cycle from Execute and buffers them in an in-order FIFO.
- Issues exactly one PHT counter update per cycle to the predictor's single update port.
- On a mispredict, produces the corrected global history for fetch-side recovery; sits between the EX stage and gshare.

Parameters:
- WIDTH, 2, number of Execute resolution lanes; lane 0 is oldest in program order.
- BHR_SIZE, 6, global history bits; the PHT index width equals BHR_SIZE.
- Q_DEPTH, 8, update FIFO entries; power of two, and Q_DEPTH >= 2*WIDTH.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  WIDTH  lane carries a resolved conditional branch.
- ex_pc  in  WIDTH x 32  branch PC per lane.
- ex_ghr  in  WIDTH x BHR_SIZE  history snapshot taken at prediction time.
- ex_taken  in  WIDTH  actual outcome.
- ex_mispredict  in  WIDTH  predicted direction differed from the actual outcome.
- ex_ready  out  1  asserted when the FIFO can accept WIDTH entries this cycle.
- upd_valid  out  1  PHT update request.
- upd_idx  out  BHR_SIZE  PHT index to train.
- upd_taken  out  1  outcome used to train the 2-bit counter.
- upd_ready  in  1  predictor accepts the update this cycle.
- recover_valid  out  1  one-cycle pulse: overwrite the speculative history.
- recover_ghr  out  BHR_SIZE  corrected history.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: FIFO empty, head=tail=count=0, FSM=IDLE. Outputs: ex_ready=1, upd_valid=0, upd_idx=0, upd_taken=0, recover_valid=0, recover_ghr=all ones (matches the predictor's reset history), busy=0.
- Reset asserted mid-operation discards every queued entry and any pending recovery in the same edge.
- Index computation happens at enqueue: idx = ex_pc[BHR_SIZE+1:2] XOR ex_ghr. Each entry stores only {idx, taken}.
- Enqueue rule:
  - Only when ex_ready=1.
  - Valid lanes are written in lane order into consecutive slots starting at tail. Invalid lanes consume no slot.
  - If lane k is the lowest-numbered lane with ex_valid & ex_mispredict, that lane is enqueued and lanes above k are dropped as wrong-path.
  - If ex_ready=0, EX must hold its inputs; nothing is enqueued and no recovery is generated.
- ex_ready = (Q_DEPTH - count) >= WIDTH. It is combinational from registered count, so a same-cycle dequeue is not credited.
- Dequeue:
  - upd_valid = (count != 0), with upd_idx and upd_taken driven from the head entry.
  - The head advances on upd_valid & upd_ready.
  - Enqueue and dequeue in the same cycle are both allowed: count_next = count + n_enq - deq.
  - Pointers wrap modulo Q_DEPTH.
- FIFO latency: an entry enqueued at edge N is first visible on upd_* in cycle N+1 if the FIFO was empty.
- Recovery:
  - The oldest mispredicting lane accepted at edge N drives recover_valid=1 for cycle N+1 only.
  - recover_ghr = {ex_ghr[BHR_SIZE-2:0], ex_taken}, registered.
  - recover_ghr holds its value after the pulse.
  - A second mispredict accepted at N+1 produces a new pulse at N+2, using the newer value.
- FSM states:
  - IDLE: count==0 and no pending recovery.
  - DRAIN: count>0.
  - RECOVER: the single cycle in which recover_valid=1.
- FSM transitions:
  - IDLE->DRAIN on enqueue without mispredict.
  - Any state->RECOVER on an accepted mispredict.
  - RECOVER->DRAIN if count_next>0, else IDLE.
  - DRAIN->IDLE when the last entry is dequeued with no enqueue.
  - Draining continues during RECOVER; already-queued correct-path entries are never flushed.
- Full: count==Q_DEPTH forces ex_ready=0. Overflow is impossible by construction; an assertion checks count <= Q_DEPTH.
- Empty: upd_valid=0; upd_idx and upd_taken hold their last values.

Decomposition:
- Shared package bp_pkg:
  - BHR_SIZE, PHT_SIZE, PHT_WIDTH constants.
  - Typedef pht_upd_t {idx, taken}.
  - FSM enum upd_state_e {IDLE, DRAIN, RECOVER}.
  - Function pht_index(pc, ghr).
- Sub-module: bp_upd_fifo, a multi-enqueue (WIDTH), single-dequeue circular buffer with count output.
- The top level owns lane compaction, wrong-path masking, the FSM and the recovery register.

Test Plan:
- Reset, then idle 3 cycles -> upd_valid=0, ex_ready=1, recover_ghr=6'b111111, busy=0.
- Lane0 pc=0x0000_0010, ghr=6'b000001, taken=1, upd_ready=1 -> next cycle upd_valid=1, upd_idx=6'b000101, upd_taken=1; FIFO empty the cycle after.
- Both lanes valid every cycle with upd_ready=0 -> after 4 cycles count=8 and ex_ready=0. Raise upd_ready -> entries emerge in enqueue order, and ex_ready returns once count<=6.
- Lane0 mispredict ghr=6'b101010 taken=0, lane1 valid -> lane1 dropped (count+1 only); next cycle recover_valid=1, recover_ghr=6'b010100 for exactly one cycle.
- Mispredicts at consecutive edges (ghr 6'b000011 taken=1, then 6'b111000 taken=0) -> pulses in two consecutive cycles carrying 6'b000111 then 6'b110000.
- Reset asserted with 5 entries queued and a recovery pending -> following cycle count=0, upd_valid=0, recover_valid=0, FSM=IDLE.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared gshare predictor definitions: history width, PHT geometry, the
// queued update record, the update-controller FSM states and the index hash.
package bp_pkg;

  localparam int BHR_SIZE  = 6;
  localparam int PHT_SIZE  = 1 << BHR_SIZE;
  localparam int PHT_WIDTH = 2;

  typedef struct packed {
    logic [BHR_SIZE-1:0] idx;
    logic                taken;
  } pht_upd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } upd_state_e;

  // Word-aligned PC bits folded with the history snapshot taken at prediction.
  function automatic logic [BHR_SIZE-1:0] pht_index(input logic [31:0]         pc,
                                                    input logic [BHR_SIZE-1:0] ghr);
    return pc[BHR_SIZE+1:2] ^ ghr;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// In-order circular buffer for PHT updates: up to WIDTH writes per cycle into
// consecutive slots at the tail, one read per cycle from the head.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter  int WIDTH   = 2,
  parameter  int Q_DEPTH = 8,
  localparam int PTR_W   = $clog2(Q_DEPTH),
  localparam int CNT_W   = PTR_W + 1,
  localparam int ENQ_W   = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ENQ_W-1:0]     i_n_enq,
  input  pht_upd_t [WIDTH-1:0] i_wr_data,
  input  logic                 i_deq,
  output pht_upd_t             o_head,
  output logic [CNT_W-1:0]     o_count
);

  pht_upd_t         r_mem [Q_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Slots 0..i_n_enq-1 of i_wr_data are already compacted by the caller.
  always_ff @(posedge clock) begin
    for (int j = 0; j < WIDTH; j++) begin
      if (ENQ_W'(j) < i_n_enq) r_mem[r_tail + PTR_W'(j)] <= i_wr_data[j];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(i_n_enq);
      r_head  <= r_head + PTR_W'(i_deq);
      r_count <= r_count + CNT_W'(i_n_enq) - CNT_W'(i_deq);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (r_count <= CNT_W'(Q_DEPTH));
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/gshare_update_ctrl.sv
// Collects resolved branches from Execute, queues one PHT training update per
// branch, drains them one per cycle and produces mispredict history recovery.
module gshare_update_ctrl
  import bp_pkg::*;
#(
  parameter  int WIDTH   = 2,
  parameter  int Q_DEPTH = 8,
  localparam int PTR_W   = $clog2(Q_DEPTH),
  localparam int CNT_W   = PTR_W + 1,
  localparam int ENQ_W   = $clog2(WIDTH + 1),
  localparam int SLOT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [WIDTH-1:0]                 ex_valid,
  input  logic [WIDTH-1:0][31:0]           ex_pc,
  input  logic [WIDTH-1:0][BHR_SIZE-1:0]   ex_ghr,
  input  logic [WIDTH-1:0]                 ex_taken,
  input  logic [WIDTH-1:0]                 ex_mispredict,
  output logic                             ex_ready,
  output logic                             upd_valid,
  output logic [BHR_SIZE-1:0]              upd_idx,
  output logic                             upd_taken,
  input  logic                             upd_ready,
  output logic                             recover_valid,
  output logic [BHR_SIZE-1:0]              recover_ghr,
  output logic                             busy
);

  logic [CNT_W-1:0]     w_count;
  logic [CNT_W-1:0]     w_count_next;
  pht_upd_t             w_head;
  pht_upd_t [WIDTH-1:0] w_slot;
  logic [ENQ_W-1:0]     w_n_enq;
  logic                 w_mp_hit;
  logic [BHR_SIZE-1:0]  w_mp_ghr;
  logic                 w_deq;
  logic                 w_unused_pc;
  upd_state_e           r_state;
  upd_state_e           w_state_next;
  pht_upd_t             r_hold;
  logic [BHR_SIZE-1:0]  r_rec_ghr;

  assign ex_ready    = (w_count <= CNT_W'(Q_DEPTH - WIDTH));
  assign upd_valid   = (w_count != '0);
  assign w_deq       = upd_valid & upd_ready;
  assign w_unused_pc = ^ex_pc;

  // Compact valid lanes in program order; the oldest mispredict ends the group.
  always_comb begin
    w_slot   = '0;
    w_n_enq  = '0;
    w_mp_hit = 1'b0;
    w_mp_ghr = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (ex_ready && ex_valid[k] && !w_mp_hit) begin
        w_slot[w_n_enq[SLOT_W-1:0]] = '{idx: pht_index(ex_pc[k], ex_ghr[k]), taken: ex_taken[k]};
        w_n_enq = w_n_enq + 1'b1;
        if (ex_mispredict[k]) begin
          w_mp_hit = 1'b1;
          w_mp_ghr = {ex_ghr[k][BHR_SIZE-2:0], ex_taken[k]};
        end
      end
    end
  end

  assign w_count_next = w_count + CNT_W'(w_n_enq) - CNT_W'(w_deq);

  bp_upd_fifo #(
    .WIDTH   (WIDTH),
    .Q_DEPTH (Q_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_n_enq   (w_n_enq),
    .i_wr_data (w_slot),
    .i_deq     (w_deq),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_mp_hit) begin
      w_state_next = RECOVER;
    end else begin
      case (r_state)
        IDLE:    if (w_n_enq != '0) w_state_next = DRAIN;
        DRAIN:   if (w_count_next == '0) w_state_next = IDLE;
        RECOVER: w_state_next = (w_count_next != '0) ? DRAIN : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Reset history is all ones so fetch and predictor agree out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_rec_ghr <= '1;
    end else begin
      r_state <= w_state_next;
      if (upd_valid) r_hold <= w_head;
      if (w_mp_hit) r_rec_ghr <= w_mp_ghr;
    end
  end

  assign upd_idx       = upd_valid ? w_head.idx : r_hold.idx;
  assign upd_taken     = upd_valid ? w_head.taken : r_hold.taken;
  assign recover_valid = (r_state == RECOVER);
  assign recover_ghr   = r_rec_ghr;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_gshare_update_ctrl.sv
// Scoreboard bench for gshare_update_ctrl: randomized and directed EX traffic
// against a queue-based reference model of the update and recovery streams.
module tb_gshare_update_ctrl;
  import bp_pkg::*;

  localparam int WIDTH   = 2;
  localparam int Q_DEPTH = 8;

  logic                           clock = 1'b0;
  logic                           reset = 1'b1;
  logic [WIDTH-1:0]               ex_valid = '0;
  logic [WIDTH-1:0][31:0]         ex_pc = '0;
  logic [WIDTH-1:0][BHR_SIZE-1:0] ex_ghr = '0;
  logic [WIDTH-1:0]               ex_taken = '0;
  logic [WIDTH-1:0]               ex_mispredict = '0;
  logic                           upd_ready = 1'b0;
  logic                           ex_ready;
  logic                           upd_valid;
  logic [BHR_SIZE-1:0]            upd_idx;
  logic                           upd_taken;
  logic                           recover_valid;
  logic [BHR_SIZE-1:0]            recover_ghr;
  logic                           busy;

  gshare_update_ctrl #(.WIDTH(WIDTH), .Q_DEPTH(Q_DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_ghr        (ex_ghr),
    .ex_taken      (ex_taken),
    .ex_mispredict (ex_mispredict),
    .ex_ready      (ex_ready),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .upd_ready     (upd_ready),
    .recover_valid (recover_valid),
    .recover_ghr   (recover_ghr),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int taken;
  } exp_t;

  exp_t mq[$];
  int   rq[$];
  exp_t pend_q[$];
  int   pend_rec[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   drove_reset = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One EX cycle: commit what the previous edge accepted, then present new inputs.
  task automatic step(input logic [1:0] v, input logic [1:0][31:0] pc,
                      input logic [1:0][5:0] ghr, input logic [1:0] tk,
                      input logic [1:0] mp, input logic urdy, input logic rst);
    @(posedge clock);
    if (drove_reset) begin
      mq.delete(); rq.delete(); pend_q.delete(); pend_rec.delete();
    end
    while (pend_q.size() != 0) mq.push_back(pend_q.pop_front());
    while (pend_rec.size() != 0) rq.push_back(pend_rec.pop_front());
    #1;
    ex_valid = v; ex_pc = pc; ex_ghr = ghr; ex_taken = tk; ex_mispredict = mp;
    upd_ready = urdy; reset = rst; drove_reset = rst;
    if (!rst && (Q_DEPTH - mq.size()) >= WIDTH) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (v[k]) begin
          pend_q.push_back('{idx: (int'(pc[k] / 4) % 64) ^ int'(ghr[k]), taken: int'(tk[k])});
          if (mp[k]) begin
            pend_rec.push_back((int'(ghr[k]) * 2 + int'(tk[k])) % 64);
            break;
          end
        end
      end
    end
  endtask

  task automatic idle(input logic urdy, input logic rst);
    step(2'b00, '0, '0, 2'b00, 2'b00, urdy, rst);
  endtask

  task automatic rand_step(input int mp_pct, input int rdy_pct, input int vld_pct);
    logic [1:0]        v, tk, mp;
    logic [1:0][31:0]  pc;
    logic [1:0][5:0]   ghr;
    for (int k = 0; k < 2; k++) begin
      v[k]   = ($urandom_range(99) < vld_pct);
      tk[k]  = $urandom_range(1);
      mp[k]  = ($urandom_range(99) < mp_pct);
      pc[k]  = $urandom;
      ghr[k] = 6'($urandom);
    end
    step(v, pc, ghr, tk, mp, ($urandom_range(99) < rdy_pct), 1'b0);
  endtask

  // Monitor: compares DUT outputs with the model each cycle, retires dequeued entries.
  initial begin
    exp_t hold;
    int   last_ghr;
    bit   ev, er;
    hold = '{idx: 0, taken: 0};
    last_ghr = 63;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        ev = (mq.size() != 0);
        er = (rq.size() != 0);
        chk("ex_ready", int'(ex_ready), int'((Q_DEPTH - mq.size()) >= WIDTH));
        chk("upd_valid", int'(upd_valid), int'(ev));
        if (ev) hold = mq[0];
        chk("upd_idx", int'(upd_idx), hold.idx);
        chk("upd_taken", int'(upd_taken), hold.taken);
        if (er) last_ghr = rq.pop_front();
        chk("recover_valid", int'(recover_valid), int'(er));
        chk("recover_ghr", int'(recover_ghr), last_ghr);
        chk("busy", int'(busy), int'(ev || er));
        if (ev && upd_ready) void'(mq.pop_front());
        if (reset) begin
          hold = '{idx: 0, taken: 0};
          last_ghr = 63;
        end
      end
    end
  end

  initial begin
    logic [1:0][31:0] pc2;
    logic [1:0][5:0]  g2;
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (3) idle(1'b0, 1'b0);
    @(negedge clock);
    chk("rst_recover_ghr", int'(recover_ghr), 6'b111111);
    chk("rst_ex_ready", int'(ex_ready), 1);

    pc2 = '0; pc2[0] = 32'h0000_0010;
    g2  = '0; g2[0]  = 6'b000001;
    step(2'b01, pc2, g2, 2'b01, 2'b00, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    @(negedge clock);
    chk("tp_idx", int'(upd_idx), 6'b000101);
    chk("tp_taken", int'(upd_taken), 1);
    idle(1'b1, 1'b0);
    @(negedge clock);
    chk("tp_empty_after", int'(upd_valid), 0);
    repeat (2) idle(1'b1, 1'b0);

    repeat (4) rand_step(0, 0, 100);
    rand_step(0, 0, 100);
    @(negedge clock);
    chk("full_ex_ready", int'(ex_ready), 0);
    repeat (10) idle(1'b1, 1'b0);

    pc2[0] = $urandom; pc2[1] = $urandom;
    g2[0] = 6'b101010; g2[1] = 6'b010101;
    step(2'b11, pc2, g2, 2'b10, 2'b01, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    @(negedge clock);
    chk("mp_pulse", int'(recover_valid), 1);
    chk("mp_ghr", int'(recover_ghr), 6'b010100);
    repeat (3) idle(1'b1, 1'b0);

    g2[0] = 6'b000011;
    step(2'b01, pc2, g2, 2'b01, 2'b01, 1'b1, 1'b0);
    g2[0] = 6'b111000;
    step(2'b01, pc2, g2, 2'b00, 2'b01, 1'b1, 1'b0);
    @(negedge clock);
    chk("mp2_ghr_a", int'(recover_ghr), 6'b000111);
    idle(1'b1, 1'b0);
    @(negedge clock);
    chk("mp2_pulse_b", int'(recover_valid), 1);
    chk("mp2_ghr_b", int'(recover_ghr), 6'b110000);
    repeat (3) idle(1'b1, 1'b0);

    repeat (400) rand_step(15, 60, 70);
    repeat (12) idle(1'b1, 1'b0);

    repeat (2) rand_step(0, 0, 100);
    g2[0] = 6'b011001;
    step(2'b01, pc2, g2, 2'b00, 2'b01, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    @(negedge clock);
    chk("prerst_pulse", int'(recover_valid), 1);
    idle(1'b0, 1'b0);
    @(negedge clock);
    chk("midrst_upd_valid", int'(upd_valid), 0);
    chk("midrst_recover", int'(recover_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ghr", int'(recover_ghr), 6'b111111);
    repeat (3) idle(1'b1, 1'b0);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
